t10_uart_rx: RTL and testbench

8N1 UART receiver, the companion of the team's UART transmitter. It shares the same baud parameterisation, idle-high line and LSB-first bit order. It synchronises the asynchronous serial input, detects start bits, samples at mid-bit, checks the stop bit, and holds each received byte in an output register until the consumer acknowledges it. It sits between the chip's RX pad and the team's command/data parser.

---
 rtl/t10_uart_rx.sv | 150 +++++++++++++++
 tb/tb_t10_uart_rx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/t10_uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling, stop-bit check and a
// held output byte with ready/ack handshake and sticky overrun.
module t10_uart_rx #(
    parameter int unsigned CLKS_PER_BAUD = 1041,
    parameter int unsigned CNT_W         = $clog2(CLKS_PER_BAUD + 1)
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       rx_serial,
    input  logic       rx_ack,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ready,
    output logic       overrun,
    output logic       framing_err,
    output logic       rx_busy
);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    localparam logic [CNT_W-1:0] HalfCnt = CNT_W'(CLKS_PER_BAUD / 2 - 1);
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CLKS_PER_BAUD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             s1_q, s2_q, s_prev_q;
    logic [7:0]       byte_q, byte_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
    logic             overrun_q, overrun_d;
    logic             ferr_q, ferr_d;

    logic fall;
    logic stop_sample;

    // Only a genuine 1->0 transition starts a frame, so a held-low break never retriggers.
    assign fall        = s_prev_q & ~s2_q;
    assign stop_sample = (state_q == StStop) && (cnt_q == FullCnt);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            s1_q      <= 1'b1;
            s2_q      <= 1'b1;
            s_prev_q  <= 1'b1;
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            s1_q      <= rx_serial;
            s2_q      <= s1_q;
            s_prev_q  <= s2_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (fall) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == HalfCnt) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = s2_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StData: begin
                if (cnt_q == FullCnt) begin
                    cnt_d              = '0;
                    shift_d[bit_idx_q] = s2_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStop: begin
                if (cnt_q == FullCnt) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        byte_d    = byte_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        ready_d   = ready_q;
        overrun_d = overrun_q;
        if (stop_sample && s2_q) begin
            byte_d    = shift_q;
            valid_d   = 1'b1;
            ready_d   = 1'b1;
            // An ack in the same cycle consumed the old byte, so no overrun.
            overrun_d = ~rx_ack & (overrun_q | ready_q);
        end else begin
            if (stop_sample) begin
                ferr_d = 1'b1;
            end
            if (rx_ack) begin
                ready_d   = 1'b0;
                overrun_d = 1'b0;
            end
        end
    end

    assign rx_byte     = byte_q;
    assign rx_valid    = valid_q;
    assign rx_ready    = ready_q;
    assign overrun     = overrun_q;
    assign framing_err = ferr_q;
    assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_t10_uart_rx.sv
// Directed bench for t10_uart_rx at 16 clocks per bit.
module tb_t10_uart_rx;

    localparam int unsigned Cpb = 16;

    logic       clk = 1'b0;
    logic       nRst;
    logic       rx_serial;
    logic       rx_ack;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       framing_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int v0, f0, b0;

    t10_uart_rx #(
        .CLKS_PER_BAUD(Cpb)
    ) dut (
        .clk        (clk),
        .nRst       (nRst),
        .rx_serial  (rx_serial),
        .rx_ack     (rx_ack),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .overrun    (overrun),
        .framing_err(framing_err),
        .rx_busy    (rx_busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (framing_err) ferr_cnt++;
        if (rx_busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; each bit is held for Cpb clocks, LSB first.
    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_serial = bits[i];
            wait_cycles(Cpb);
        end
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
    endtask

    task automatic snap();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        b0 = busy_cnt;
    endtask

    initial begin
        nRst      = 1'b0;
        rx_serial = 1'b1;
        rx_ack    = 1'b0;
        wait_cycles(3);
        check("rst_byte", 32'(rx_byte), 32'h00);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_ready", 32'(rx_ready), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_ferr", 32'(framing_err), 32'd0);
        check("rst_busy", 32'(rx_busy), 32'd0);
        nRst = 1'b1;
        wait_cycles(5);

        // Basic frame
        snap();
        send_frame(8'hA5, 1'b1);
        wait_cycles(4);
        check("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("a5_byte", 32'(rx_byte), 32'hA5);
        check("a5_ready", 32'(rx_ready), 32'd1);
        check("a5_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("a5_overrun", 32'(overrun), 32'd0);
        wait_cycles(20);
        check("a5_ready_held", 32'(rx_ready), 32'd1);
        pulse_ack();
        check("a5_ready_acked", 32'(rx_ready), 32'd0);
        wait_cycles(5);

        // Glitch: busy from the edge detect until the half-bit sample
        snap();
        rx_serial = 1'b0;
        wait_cycles(4);
        rx_serial = 1'b1;
        wait_cycles(30);
        check("glitch_busy_cycles", 32'(busy_cnt - b0), 32'd8);
        check("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("glitch_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);
        check("glitch_busy_end", 32'(rx_busy), 32'd0);

        // Framing error followed by a held-low break
        snap();
        send_frame(8'h3C, 1'b0);
        wait_cycles(40);
        check("ferr_cnt", 32'(ferr_cnt - f0), 32'd1);
        check("ferr_valid_cnt", 32'(valid_cnt - v0), 32'd0);
        check("ferr_byte_kept", 32'(rx_byte), 32'hA5);
        check("ferr_ready", 32'(rx_ready), 32'd0);
        check("ferr_busy_cycles", 32'(busy_cnt - b0), 32'd152);
        check("ferr_busy_end", 32'(rx_busy), 32'd0);
        rx_serial = 1'b1;
        wait_cycles(20);

        // Back-to-back without ack
        snap();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        wait_cycles(4);
        check("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
        check("b2b_byte", 32'(rx_byte), 32'h22);
        check("b2b_ready", 32'(rx_ready), 32'd1);
        check("b2b_overrun", 32'(overrun), 32'd1);
        pulse_ack();
        check("b2b_ack_ready", 32'(rx_ready), 32'd0);
        check("b2b_ack_overrun", 32'(overrun), 32'd0);
        wait_cycles(5);

        // Ack lands on the exact stop-sample edge (posedge 155 after the start drive)
        send_frame(8'h11, 1'b1);
        check("sameack_pre_ready", 32'(rx_ready), 32'd1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                repeat (2 + 1 + Cpb / 2 + 9 * Cpb - 1) @(posedge clk);
                @(negedge clk);
                rx_ack = 1'b1;
                @(negedge clk);
                rx_ack = 1'b0;
            end
        join
        check("sameack_byte", 32'(rx_byte), 32'h22);
        check("sameack_ready", 32'(rx_ready), 32'd1);
        check("sameack_overrun", 32'(overrun), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF
        rx_serial = 1'b0;
        wait_cycles(Cpb);
        rx_serial = 1'b1;
        wait_cycles(4 * Cpb + Cpb / 2);
        check("midrst_busy_before", 32'(rx_busy), 32'd1);
        nRst = 1'b0;
        #1;
        check("midrst_byte", 32'(rx_byte), 32'h00);
        check("midrst_ready", 32'(rx_ready), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_busy", 32'(rx_busy), 32'd0);
        @(negedge clk);
        nRst = 1'b1;
        wait_cycles(20);
        snap();
        send_frame(8'h5A, 1'b1);
        wait_cycles(4);
        check("post_valid_cnt", 32'(valid_cnt - v0), 32'd1);
        check("post_byte", 32'(rx_byte), 32'h5A);
        check("post_ready", 32'(rx_ready), 32'd1);
        check("post_ferr_cnt", 32'(ferr_cnt - f0), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
